// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for an RV32I subset (LBU, SB, ADD, SUB, ADDI, LUI,
// BNE, JAL, JALR) driving a shared-memory datapath. One memory port serves
// both instruction fetch and data access. The FSM waits on a memory-ready
// handshake and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             AdrSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [2:0]       MemSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUControl,
  output logic             ALUSrc,
  output logic [2:0]       ImmSrc,
  output logic             RegWrite,
  output logic [1:0]       RegWSrc,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t     state, nxt;
  logic       legal, is_sub;
  logic [2:0] imm_dec;
  logic       adr, mr, mw, irw, pcw, rw, asrc;
  logic [1:0] pcs, rws;
  logic [2:0] aluc, imm;

  assign legal = (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_OPIMM) ||
                 (op == OP_OP)    || (op == OP_LUI)    || (op == OP_BRANCH) ||
                 (op == OP_JAL)   || (op == OP_JALR);
  // Only register-register OP may subtract; ADDI's upper immediate bits
  // alias funct7 and must never select sub.
  assign is_sub = (op == OP_OP) && (funct7 == 7'b0100000);

  // Immediate format follows the opcode; it stays valid through WB so the
  // PC+Imm adder sees the right immediate at the JAL update edge.
  always_comb begin
    imm_dec = 3'd0;
    case (op)
      OP_STORE:  imm_dec = 3'd2;
      OP_BRANCH: imm_dec = 3'd1;
      OP_JAL:    imm_dec = 3'd3;
      OP_LUI:    imm_dec = 3'd4;
      default:   imm_dec = 3'd0;
    endcase
  end

  // State register; reset always restarts at FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= nxt;
  end

  // Next-state and Moore-decoded control (PCSrc in EXEC also uses Zero).
  always_comb begin
    nxt  = state;
    adr  = 1'b0;
    mr   = 1'b0;
    mw   = 1'b0;
    irw  = 1'b0;
    pcw  = 1'b0;
    rw   = 1'b0;
    pcs  = 2'b00;
    rws  = 2'b00;
    aluc = 3'b000;
    asrc = 1'b0;
    imm  = (state == FETCH || state == HALT) ? 3'd0 : imm_dec;
    case (state)
      FETCH: begin
        mr = 1'b1;
        if (mem_ready) begin
          irw = 1'b1;
          nxt = DECODE;
        end
      end
      DECODE: nxt = legal ? EXEC : HALT;
      EXEC: begin
        nxt = WB;
        case (op)
          OP_OP:    aluc = is_sub ? 3'b001 : 3'b000;
          OP_OPIMM: asrc = 1'b1;
          OP_LUI: begin
            aluc = 3'b010;
            asrc = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            asrc = 1'b1;
            nxt  = MEM;
          end
          OP_BRANCH: begin
            aluc = 3'b001;
            pcw  = 1'b1;
            pcs  = Zero ? 2'b00 : 2'b01;
            nxt  = FETCH;
          end
          OP_JALR:  asrc = 1'b1;
          default:  ;
        endcase
      end
      MEM: begin
        adr = 1'b1;
        mr  = (op == OP_LOAD);
        mw  = (op == OP_STORE);
        if (mem_ready) begin
          if (op == OP_STORE) begin
            pcw = 1'b1;
            nxt = FETCH;
          end else begin
            nxt = WB;
          end
        end
      end
      WB: begin
        rw  = 1'b1;
        pcw = 1'b1;
        nxt = FETCH;
        if (op == OP_LOAD)                       rws = 2'b01;
        else if (op == OP_JAL || op == OP_JALR)  rws = 2'b10;
        if (op == OP_JAL)       pcs = 2'b01;
        else if (op == OP_JALR) pcs = 2'b10;
      end
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  // Strobes are forced low combinationally while reset is held so a reset
  // landing mid-access drops the memory request at once.
  assign AdrSrc     = adr;
  assign MemRead    = mr  & ~rst;
  assign MemWrite   = mw  & ~rst;
  assign IRWrite    = irw & ~rst;
  assign PCWrite    = pcw & ~rst;
  assign RegWrite   = rw  & ~rst;
  assign halted     = (state == HALT) & ~rst;
  assign PCSrc      = pcs;
  assign RegWSrc    = rws;
  assign ALUControl = aluc;
  assign ALUSrc     = asrc;
  assign ImmSrc     = imm;
  assign MemSrc     = funct3;

  // Retired-instruction counter: one tick per PC update, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          instret <= '0;
    else if (PCWrite) instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes the
// expected control vector and retired count; a negedge monitor pops and
// compares against the DUT.
module tb_multicycle_control;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // {halted,AdrSrc,MemRead,MemWrite,IRWrite,PCWrite,RegWrite,PCSrc,RegWSrc,ALUControl,ALUSrc,ImmSrc}
  localparam logic [17:0] MS = 18'h2F800; // halted + all strobes
  localparam logic [17:0] MA = 18'h10000; // AdrSrc
  localparam logic [17:0] MP = 18'h00600; // PCSrc
  localparam logic [17:0] MW = 18'h00180; // RegWSrc
  localparam logic [17:0] ML = 18'h00070; // ALUControl
  localparam logic [17:0] MB = 18'h00008; // ALUSrc
  localparam logic [17:0] MI = 18'h00007; // ImmSrc

  logic        clk, rst;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
  logic        Zero, mem_ready;
  logic        AdrSrc, MemRead, MemWrite, IRWrite, PCWrite, ALUSrc, RegWrite, halted;
  logic [2:0]  MemSrc, ALUControl, ImmSrc;
  logic [1:0]  PCSrc, RegWSrc;
  logic [31:0] instret;
  logic [17:0] obs;

  typedef struct {
    string       tag;
    logic [17:0] mask;
    logic [17:0] val;
    logic [31:0] ret;
  } exp_t;

  exp_t        sbq[$];
  exp_t        ce;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_ret = '0;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .AdrSrc(AdrSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemSrc(MemSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .RegWSrc(RegWSrc), .halted(halted), .instret(instret)
  );

  assign obs = {halted, AdrSrc, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
                PCSrc, RegWSrc, ALUControl, ALUSrc, ImmSrc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

  // Scoreboard consumer: sample mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      ce = sbq.pop_front();
      total++;
      if ((obs & ce.mask) !== ce.val) begin
        bad++;
        $display("FAIL %s: ctrl got %h want %h (mask %h)", ce.tag, obs & ce.mask, ce.val, ce.mask);
      end
      total++;
      if (instret !== ce.ret) begin
        bad++;
        $display("FAIL %s: instret got %0d want %0d", ce.tag, instret, ce.ret);
      end
    end
  end

  function automatic logic [17:0] ov(bit h, bit adr, bit mr, bit mw, bit irw, bit pcw, bit rw,
                                     logic [1:0] pcs, logic [1:0] rws, logic [2:0] alu,
                                     bit asrc, logic [2:0] imm);
    return {h, adr, mr, mw, irw, pcw, rw, pcs, rws, alu, asrc, imm};
  endfunction

  // Drive one cycle and push its expectation; returns just after the next edge.
  task automatic cyc(input string tag, input bit rdy, input bit z,
                     input logic [17:0] m, input logic [17:0] v);
    mem_ready = rdy;
    Zero      = z;
    sbq.push_back('{tag, m, v, exp_ret});
    if (m[12] && v[12]) exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op = o; funct3 = f3; funct7 = f7;
  endtask

  task automatic fetch(input int stalls);
    for (int i = 0; i < stalls; i++)
      cyc("fetch_wait", 1'b0, 1'b0, MS | MA, ov(0,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,3'd0));
    cyc("fetch", 1'b1, 1'b0, MS | MA, ov(0,0,1,0,1,0,0,2'b00,2'b00,3'b000,0,3'd0));
  endtask

  task automatic decode();
    cyc("decode", 1'b1, 1'b0, MS, 18'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ins(OPIMM, 3'b000, 7'b0);
    @(posedge clk); #1;
    cyc("reset_a", 1'b1, 1'b0, MS, 18'h0);
    cyc("reset_b", 1'b0, 1'b0, MS, 18'h0);
    rst = 1'b0;
  endtask

  task automatic test_addi();
    set_ins(OPIMM, 3'b000, 7'b0);
    fetch(0);
    decode();
    cyc("addi_exec", 1'b1, 1'b0, MS | ML | MB | MI, ov(0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,3'd0));
    cyc("addi_wb", 1'b1, 1'b0, MS | MP | MW, ov(0,0,0,0,0,1,1,2'b00,2'b00,3'b000,0,3'd0));
    total++;
    if (instret !== exp_ret) begin
      bad++;
      $display("FAIL addi_instret: got %0d want %0d", instret, exp_ret);
    end
  endtask

  task automatic test_lbu_stall();
    set_ins(LOAD, 3'b100, 7'b0);
    fetch(2);
    decode();
    cyc("lbu_exec", 1'b1, 1'b0, MS | ML | MB | MI, ov(0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,3'd0));
    total++;
    if (MemSrc !== 3'b100) begin
      bad++;
      $display("FAIL lbu_memsrc: got %b want 100", MemSrc);
    end
    for (int i = 0; i < 3; i++)
      cyc("lbu_mem_wait", 1'b0, 1'b0, MS | MA, ov(0,1,1,0,0,0,0,2'b00,2'b00,3'b000,0,3'd0));
    cyc("lbu_mem", 1'b1, 1'b0, MS | MA, ov(0,1,1,0,0,0,0,2'b00,2'b00,3'b000,0,3'd0));
    cyc("lbu_wb", 1'b1, 1'b0, MS | MP | MW, ov(0,0,0,0,0,1,1,2'b00,2'b01,3'b000,0,3'd0));
  endtask

  task automatic test_bne();
    logic [31:0] start;
    start = instret;
    set_ins(BRANCH, 3'b001, 7'b0);
    fetch(0);
    decode();
    cyc("bne_taken", 1'b1, 1'b0, MS | MP | ML | MB | MI, ov(0,0,0,0,0,1,0,2'b01,2'b00,3'b001,0,3'd1));
    fetch(0);
    decode();
    cyc("bne_not_taken", 1'b1, 1'b1, MS | MP | ML | MB | MI, ov(0,0,0,0,0,1,0,2'b00,2'b00,3'b001,0,3'd1));
    total++;
    if (instret !== start + 32'd2) begin
      bad++;
      $display("FAIL bne_instret: got %0d want %0d", instret, start + 32'd2);
    end
  endtask

  task automatic test_jumps();
    set_ins(JAL, 3'b000, 7'b0);
    fetch(0);
    decode();
    cyc("jal_exec", 1'b1, 1'b0, MS | MI, ov(0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,3'd3));
    cyc("jal_wb", 1'b1, 1'b0, MS | MP | MW, ov(0,0,0,0,0,1,1,2'b01,2'b10,3'b000,0,3'd0));
    set_ins(JALR, 3'b000, 7'b0);
    fetch(0);
    decode();
    cyc("jalr_exec", 1'b1, 1'b0, MS | ML | MB | MI, ov(0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,3'd0));
    cyc("jalr_wb", 1'b1, 1'b0, MS | MP | MW, ov(0,0,0,0,0,1,1,2'b10,2'b10,3'b000,0,3'd0));
  endtask

  task automatic test_alu_sel();
    set_ins(OPIMM, 3'b000, 7'b0100000);
    fetch(0);
    decode();
    cyc("addi_f7_exec", 1'b1, 1'b0, MS | ML | MB, ov(0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,3'd0));
    cyc("addi_f7_wb", 1'b1, 1'b0, MS, ov(0,0,0,0,0,1,1,2'b00,2'b00,3'b000,0,3'd0));
    set_ins(OPR, 3'b000, 7'b0100000);
    fetch(0);
    decode();
    cyc("sub_exec", 1'b1, 1'b0, MS | ML | MB, ov(0,0,0,0,0,0,0,2'b00,2'b00,3'b001,0,3'd0));
    cyc("sub_wb", 1'b1, 1'b0, MS | MP | MW, ov(0,0,0,0,0,1,1,2'b00,2'b00,3'b000,0,3'd0));
  endtask

  task automatic test_store();
    set_ins(STORE, 3'b000, 7'b0);
    fetch(1);
    decode();
    cyc("sb_exec", 1'b1, 1'b0, MS | ML | MB | MI, ov(0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,3'd2));
    cyc("sb_mem", 1'b1, 1'b0, MS | MA | MP, ov(0,1,0,1,0,1,0,2'b00,2'b00,3'b000,0,3'd0));
  endtask

  task automatic test_halt_and_reset();
    set_ins(7'b0000000, 3'b000, 7'b0);
    fetch(0);
    decode();
    for (int i = 0; i < 20; i++)
      cyc("halt", bit'($urandom_range(0, 1)), 1'b0, MS, ov(1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,3'd0));
    rst = 1'b1;
    exp_ret = '0;
    cyc("halt_rst", 1'b1, 1'b0, MS, 18'h0);
    rst = 1'b0;
    test_addi();
    set_ins(STORE, 3'b000, 7'b0);
    fetch(0);
    decode();
    cyc("sb2_exec", 1'b1, 1'b0, MS | MB | MI, ov(0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,3'd2));
    cyc("sb2_mem_wait", 1'b0, 1'b0, MS | MA, ov(0,1,0,1,0,0,0,2'b00,2'b00,3'b000,0,3'd0));
    cyc("sb2_mem_wait", 1'b0, 1'b0, MS | MA, ov(0,1,0,1,0,0,0,2'b00,2'b00,3'b000,0,3'd0));
    rst = 1'b1;
    exp_ret = '0;
    cyc("mem_rst", 1'b1, 1'b0, MS, 18'h0);
    rst = 1'b0;
    fetch(0);
    decode();
  endtask

  initial begin
    rst = 1'b1; Zero = 1'b0; mem_ready = 1'b0;
    op = '0; funct3 = '0; funct7 = '0;
    test_reset();
    test_addi();
    test_lbu_stall();
    test_bne();
    test_jumps();
    test_alu_sel();
    test_store();
    test_halt_and_reset();
    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
